// File: rtl/axil_reg_slave.sv
`default_nettype none
//==============================================================================
// Module      : axil_reg_slave
// Description : AXI4-Lite responder with four 32-bit read/write registers.
//               Register contents are exported to fabric together with a
//               one-cycle write-notify pulse per register. One outstanding
//               write and one outstanding read; both channels run
//               concurrently and never stall each other.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
// Ports
//   S_AXI_ACLK            in   1     clock
//   S_AXI_ARESETN         in   1     synchronous active-low reset
//   S_AXI_AW* / W* / B*         write address, data, response channels
//   S_AXI_AR* / R*              read address, data channels
//   reg_out               out  128   {reg3, reg2, reg1, reg0}
//   reg_wr_pulse          out  4     bit i high one cycle when reg i written
//==============================================================================
module axil_reg_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0]   reg_out,
  output logic [3:0]                        reg_wr_pulse
);

  localparam int c_NUM_REGS = 4;
  localparam int c_STRB_W   = C_S_AXI_DATA_WIDTH / 8;

  // Register file
  logic [C_S_AXI_DATA_WIDTH-1:0] r_regs [c_NUM_REGS];

  // Write path state
  logic                          r_aw_held;
  logic                          r_w_held;
  logic                          r_bvalid;
  logic [1:0]                    r_aw_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_wdata;
  logic [c_STRB_W-1:0]           r_wstrb;
  logic [3:0]                    r_wr_pulse;

  // Read path state
  logic                          r_rvalid;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;

  // Handshake and commit decode
  logic                          w_awready;
  logic                          w_wready;
  logic                          w_arready;
  logic                          w_aw_hs;
  logic                          w_w_hs;
  logic                          w_ar_hs;
  logic                          w_commit;
  logic [1:0]                    w_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_data;
  logic [c_STRB_W-1:0]           w_strb;

  // Protection bits and the byte offset within a word carry no meaning here.
  logic w_unused;
  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                      S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Readies are gated by reset directly so they read 0 while reset is low,
  // independent of the registered state.
  assign w_awready = S_AXI_ARESETN & ~r_aw_held & ~r_bvalid;
  assign w_wready  = S_AXI_ARESETN & ~r_w_held  & ~r_bvalid;
  assign w_arready = S_AXI_ARESETN & ~r_rvalid;

  assign w_aw_hs = S_AXI_AWVALID & w_awready;
  assign w_w_hs  = S_AXI_WVALID  & w_wready;
  assign w_ar_hs = S_AXI_ARVALID & w_arready;

  // Commit as soon as both halves are available, whether held from an
  // earlier cycle or arriving on this edge.
  assign w_commit = (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs);
  assign w_idx    = r_aw_held ? r_aw_idx : S_AXI_AWADDR[3:2];
  assign w_data   = r_w_held  ? r_wdata  : S_AXI_WDATA;
  assign w_strb   = r_w_held  ? r_wstrb  : S_AXI_WSTRB;

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      r_aw_held  <= 1'b0;
      r_w_held   <= 1'b0;
      r_bvalid   <= 1'b0;
      r_aw_idx   <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_wr_pulse <= '0;
      for (int i = 0; i < c_NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      r_wr_pulse <= '0;
      if (w_aw_hs) begin
        r_aw_idx <= S_AXI_AWADDR[3:2];
      end
      if (w_w_hs) begin
        r_wdata <= S_AXI_WDATA;
        r_wstrb <= S_AXI_WSTRB;
      end
      if (w_commit) begin
        // BVALID is low whenever a commit can occur, so no B handshake
        // needs handling in this branch.
        r_aw_held  <= 1'b0;
        r_w_held   <= 1'b0;
        r_bvalid   <= 1'b1;
        r_wr_pulse <= 4'b0001 << w_idx;
        for (int b = 0; b < c_STRB_W; b++) begin
          if (w_strb[b]) begin
            r_regs[w_idx][8*b +: 8] <= w_data[8*b +: 8];
          end
        end
      end else begin
        if (w_aw_hs) begin
          r_aw_held <= 1'b1;
        end
        if (w_w_hs) begin
          r_w_held <= 1'b1;
        end
        if (r_bvalid && S_AXI_BREADY) begin
          r_bvalid <= 1'b0;
        end
      end
    end
  end

  // Read path: RDATA samples the register array before any same-edge write
  // lands, giving pre-write data on a collision.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rdata  <= r_regs[S_AXI_ARADDR[3:2]];
    end else if (r_rvalid && S_AXI_RREADY) begin
      r_rvalid <= 1'b0;
    end
  end

  generate
    for (genvar gi = 0; gi < c_NUM_REGS; gi++) begin : g_reg_out
      assign reg_out[gi*C_S_AXI_DATA_WIDTH +: C_S_AXI_DATA_WIDTH] = r_regs[gi];
    end
  endgenerate

  assign S_AXI_AWREADY = w_awready;
  assign S_AXI_WREADY  = w_wready;
  assign S_AXI_ARREADY = w_arready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = 2'b00;
  assign reg_wr_pulse  = r_wr_pulse;

endmodule
`default_nettype wire

// File: tb/tb_axil_reg_slave.sv
`default_nettype none
//==============================================================================
// Module      : tb_axil_reg_slave
// Description : Self-checking bench for axil_reg_slave. Table of directed
//               write/read vectors plus hand-written multi-cycle sequences.
//               Inputs are driven and outputs sampled on the falling edge.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_axil_reg_slave;

  logic         clk;
  logic         rst_n;
  logic [3:0]   awaddr;
  logic [2:0]   awprot;
  logic         awvalid;
  logic         awready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wvalid;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;
  logic [3:0]   araddr;
  logic [2:0]   arprot;
  logic         arvalid;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready;
  logic [127:0] reg_out;
  logic [3:0]   reg_wr_pulse;

  int n_cmp = 0;
  int n_err = 0;
  int pcnt [4];

  axil_reg_slave #(
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (4)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .reg_out       (reg_out),
    .reg_wr_pulse  (reg_wr_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count write-notify pulses per bit (each lasts one cycle).
  initial for (int i = 0; i < 4; i++) pcnt[i] = 0;
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (reg_wr_pulse[i] === 1'b1) pcnt[i] = pcnt[i] + 1;
    end
  end

  typedef struct {
    bit          wr;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // All tasks start and end at a falling edge.
  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    bit aw_done = 0;
    bit w_done  = 0;
    int n = 0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    while (!(aw_done && w_done) && n < 20) begin
      if (awvalid && awready) aw_done = 1;
      if (wvalid && wready)   w_done  = 1;
      @(negedge clk); n++;
      if (aw_done) awvalid = 1'b0;
      if (w_done)  wvalid  = 1'b0;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (!(aw_done && w_done)) chk("write_handshake_timeout", 0, 1);
    n = 0;
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    chk("bvalid", {127'd0, bvalid}, 1);
    chk("bresp", {126'd0, bresp}, 0);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] a, input logic [31:0] exp, input string name);
    int n = 0;
    araddr = a; arvalid = 1'b1;
    while (!arready && n < 20) begin @(negedge clk); n++; end
    if (!arready) chk("read_ar_timeout", 0, 1);
    @(negedge clk);
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin @(negedge clk); n++; end
    chk("rvalid", {127'd0, rvalid}, 1);
    chk(name, {96'd0, rdata}, {96'd0, exp});
    chk("rresp", {126'd0, rresp}, 0);
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  vec_t tbl [13];
  int   p0 [4];
  logic [31:0] held;

  initial begin
    tbl[0]  = '{1'b1, 4'h0, 32'h0000_0001, 4'hF, 32'h0};
    tbl[1]  = '{1'b1, 4'h4, 32'h0000_0002, 4'hF, 32'h0};
    tbl[2]  = '{1'b1, 4'h8, 32'h0000_0003, 4'hF, 32'h0};
    tbl[3]  = '{1'b1, 4'hC, 32'h0000_0004, 4'hF, 32'h0};
    tbl[4]  = '{1'b0, 4'h0, 32'h0,         4'h0, 32'h0000_0001};
    tbl[5]  = '{1'b0, 4'h4, 32'h0,         4'h0, 32'h0000_0002};
    tbl[6]  = '{1'b0, 4'h8, 32'h0,         4'h0, 32'h0000_0003};
    tbl[7]  = '{1'b0, 4'hC, 32'h0,         4'h0, 32'h0000_0004};
    tbl[8]  = '{1'b1, 4'h5, 32'hFFFF_FFFF, 4'hF, 32'h0};           // unaligned -> reg1
    tbl[9]  = '{1'b1, 4'h4, 32'h1234_5678, 4'h5, 32'h0};           // bytes 0 and 2
    tbl[10] = '{1'b0, 4'h6, 32'h0,         4'h0, 32'hFF34_FF78};
    tbl[11] = '{1'b1, 4'h0, 32'hAAAA_AAAA, 4'h0, 32'h0};           // no bytes enabled
    tbl[12] = '{1'b0, 4'h1, 32'h0,         4'h0, 32'h0000_0001};

    rst_n = 1'b0; awaddr = 0; awprot = 0; awvalid = 0; wdata = 0; wstrb = 0;
    wvalid = 0; bready = 0; araddr = 0; arprot = 0; arvalid = 0; rready = 0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_readies", {125'd0, awready, wready, arready}, 0);
    chk("reset_valids", {126'd0, bvalid, rvalid}, 0);
    chk("reset_rdata", {96'd0, rdata}, 0);
    chk("reset_reg_out", reg_out, 0);
    chk("reset_pulse", {124'd0, reg_wr_pulse}, 0);
    rst_n = 1'b1;
    #1;
    chk("release_readies", {125'd0, awready, wready, arready}, 3'b111);
    @(negedge clk);

    for (int i = 0; i < 4; i++) p0[i] = pcnt[i];
    for (int i = 0; i < 13; i++) begin
      if (tbl[i].wr) do_write(tbl[i].addr, tbl[i].data, tbl[i].strb);
      else           do_read(tbl[i].addr, tbl[i].exp, $sformatf("tbl_rdata_%0d", i));
      if (i == 7) begin
        chk("reg_out_seq", reg_out, 128'h00000004_00000003_00000002_00000001);
        for (int b = 0; b < 4; b++)
          chk($sformatf("pulse_count_%0d", b), pcnt[b] - p0[b], 1);
      end
    end

    // W presented three cycles before AW
    wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wvalid = 1'b1;
    chk("wfirst_wready", {127'd0, wready}, 1);
    @(negedge clk);
    wvalid = 1'b0;
    chk("wfirst_wready_drop", {127'd0, wready}, 0);
    @(negedge clk);
    @(negedge clk);
    chk("wfirst_no_bvalid", {127'd0, bvalid}, 0);
    awaddr = 4'h8; awvalid = 1'b1;
    chk("wfirst_awready", {127'd0, awready}, 1);
    @(negedge clk);
    awvalid = 1'b0;
    chk("wfirst_bvalid", {127'd0, bvalid}, 1);
    chk("wfirst_pulse", {124'd0, reg_wr_pulse}, 4'b0100);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk("wfirst_reg2", reg_out[95:64], 32'hDEAD_BEEF);
    do_read(4'h8, 32'hDEAD_BEEF, "wfirst_rdata");

    // BREADY held low after commit
    awaddr = 4'h0; wdata = 32'h0000_0011; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    for (int k = 0; k < 4; k++)
      chk($sformatf("bstall_%0d", k), {125'd0, bvalid, awready, wready}, 3'b100);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk("bstall_release", {125'd0, bvalid, awready, wready}, 3'b011);
    do_write(4'h0, 32'h0000_0022, 4'hF);
    chk("bstall_reg0", reg_out[31:0], 32'h0000_0022);

    // Same-edge read and write to reg3
    awaddr = 4'hC; wdata = 32'hA5A5_A5A5; wstrb = 4'hF; araddr = 4'hC;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    chk("coll_readies", {125'd0, awready, wready, arready}, 3'b111);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("coll_valids", {126'd0, bvalid, rvalid}, 2'b11);
    chk("coll_old", {96'd0, rdata}, 32'h0000_0004);
    bready = 1'b1; rready = 1'b1;
    @(negedge clk);
    bready = 1'b0; rready = 1'b0;
    do_read(4'hC, 32'hA5A5_A5A5, "coll_new");

    // Repeat with RREADY held low
    awaddr = 4'hC; wdata = 32'h5A5A_5A5A; araddr = 4'hC;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    bready = 1'b1;
    held = rdata;
    chk("coll2_old", {96'd0, held}, 32'hA5A5_A5A5);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bready = 1'b0;
      chk($sformatf("rhold_%0d", k), {95'd0, rvalid, rdata}, {95'd0, 1'b1, 32'hA5A5_A5A5});
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    do_read(4'hC, 32'h5A5A_5A5A, "coll2_new");

    // Reset the cycle after AW acceptance, before W
    awaddr = 4'h4; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_readies", {125'd0, awready, wready, arready}, 0);
    @(negedge clk);
    chk("mid_rst_reg_out", reg_out, 0);
    chk("mid_rst_bvalid", {127'd0, bvalid}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_rst_release", {125'd0, awready, wready, arready}, 3'b111);
    wdata = 32'h7777_7777; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("mid_rst_no_b_%0d", k), {127'd0, bvalid}, 0);
      @(negedge clk);
    end
    chk("mid_rst_reg_out_final", reg_out, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
